// File: rtl/bram_fifo_fwft_pkg.sv
// Shared defaults and configuration check for the BRAM-backed FIFO family.
// Future FIFO variants import the same defaults and check.
package bram_fifo_fwft_pkg;

   localparam int DEF_DATAW     = 32;
   localparam int DEF_DEPTH     = 1024;
   localparam int DEF_ADDR_LEN  = 10;
   localparam int DEF_AEMPTY_TH = 4;

   function automatic bit fifo_cfg_ok(
      input int depth,
      input int addr_len,
      input int afull_th,
      input int aempty_th
   );
      return (aempty_th < afull_th) &&
             (afull_th <= depth) &&
             ((1 << addr_len) == depth);
   endfunction

endpackage

// File: rtl/bram_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read data holds its value while re is low; contents are never reset.
module bram_sdp_ram #(
   parameter int DATAW    = 32,
   parameter int ADDR_LEN = 10
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_LEN-1:0] waddr,
   input  logic [DATAW-1:0]    wdata,
   input  logic                re,
   input  logic [ADDR_LEN-1:0] raddr,
   output logic [DATAW-1:0]    rdata
);

   logic [DATAW-1:0] mem_q [2**ADDR_LEN];
   logic [DATAW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bram_fifo_fwft.sv
// BRAM FIFO with first-word-fall-through output, occupancy count,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module bram_fifo_fwft
   import bram_fifo_fwft_pkg::*;
#(
   parameter int DATAW     = DEF_DATAW,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_LEN  = DEF_ADDR_LEN,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATAW-1:0]    data_in,
   input  logic                w_en,
   input  logic                r_en,
   output logic [DATAW-1:0]    data_out,
   output logic                valid,
   output logic                empty,
   output logic                full,
   output logic                almost_full,
   output logic                almost_empty,
   output logic [ADDR_LEN:0]   count,
   output logic                overflow,
   output logic                underflow
);

   localparam int CW = ADDR_LEN + 1;
   localparam logic [ADDR_LEN-1:0] PTR_ONE = ADDR_LEN'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (!fifo_cfg_ok(DEPTH, ADDR_LEN, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
      $error("bram_fifo_fwft: illegal DEPTH/ADDR_LEN/threshold parameters");
   end

   logic [ADDR_LEN-1:0] wptr_q, wptr_d;
   logic [ADDR_LEN-1:0] rptr_q, rptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                out_valid_q, out_valid_d;
   logic                ram_valid_q, ram_valid_d;
   logic [DATAW-1:0]    dout_q, dout_d;
   logic                valid_q, full_q, afull_q, aempty_q;
   logic                ovf_q, unf_q;

   logic                accept, pop, ram_take, ram_free, ram_re;
   logic [CW-1:0]       staged;
   logic [DATAW-1:0]    ram_rdata;

   bram_sdp_ram #(
      .DATAW    (DATAW),
      .ADDR_LEN (ADDR_LEN)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wptr_q),
      .wdata (data_in),
      .re    (ram_re),
      .raddr (rptr_q),
      .rdata (ram_rdata)
   );

   // Two-slot prefetch: RAM output register, then the output register.
   // The head is the output register if loaded, else the RAM output.
   always_comb begin
      accept   = w_en && !full_q;
      pop      = r_en && valid_q;
      ram_take = ram_valid_q && (!out_valid_q || pop);
      ram_free = !ram_valid_q || ram_take;
      staged   = CW'(out_valid_q) + CW'(ram_valid_q);
      ram_re   = ram_free && (count_q > staged);

      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      if (out_valid_q) begin
         if (pop) begin
            out_valid_d = ram_valid_q;
            if (ram_valid_q) begin
               dout_d = ram_rdata;
            end
         end
      end else if (ram_valid_q && !pop) begin
         out_valid_d = 1'b1;
         dout_d      = ram_rdata;
      end

      ram_valid_d = ram_re || (ram_valid_q && !ram_take);

      count_d = count_q;
      if (accept && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !accept) begin
         count_d = count_q - CNT_ONE;
      end

      wptr_d = accept ? wptr_q + PTR_ONE : wptr_q;
      rptr_d = ram_re ? rptr_q + PTR_ONE : rptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         ram_valid_q <= 1'b0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         full_q      <= 1'b0;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         ram_valid_q <= ram_valid_d;
         dout_q      <= dout_d;
         valid_q     <= out_valid_d || ram_valid_d;
         full_q      <= (count_d == CW'(DEPTH));
         afull_q     <= (count_d >= CW'(AFULL_TH));
         aempty_q    <= (count_d <= CW'(AEMPTY_TH));
         ovf_q       <= ovf_q || (w_en && full_q);
         unf_q       <= unf_q || (r_en && !valid_q);
      end
   end

   assign data_out     = (ram_valid_q && !out_valid_q) ? ram_rdata : dout_q;
   assign valid        = valid_q;
   assign empty        = !valid_q;
   assign full         = full_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_bram_fifo_fwft.sv
// Scoreboard bench for bram_fifo_fwft at DEPTH=16.
// Each scenario task drives stimulus and checks its own results.
module tb_bram_fifo_fwft;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AL    = 4;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic [DW-1:0] data_out;
   logic          valid, empty, full, almost_full, almost_empty;
   logic [AL:0]   count;
   logic          overflow, underflow;

   int            npass = 0;
   int            ntot = 0;
   int            mcount = 0;
   logic [DW-1:0] expq [$];

   bram_fifo_fwft #(
      .DATAW     (DW),
      .DEPTH     (DEPTH),
      .ADDR_LEN  (AL),
      .AFULL_TH  (AF),
      .AEMPTY_TH (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .w_en         (w_en),
      .r_en         (r_en),
      .data_out     (data_out),
      .valid        (valid),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // One clock: apply inputs, score a pop, record an accepted write.
   task automatic cyc(input logic we, input logic [DW-1:0] d,
                      input logic re);
      logic [DW-1:0] e;
      bit acc;
      w_en    = we;
      data_in = d;
      r_en    = re;
      acc     = we && (mcount < DEPTH);
      if (re && valid) begin
         ntot++;
         if (expq.size() == 0) begin
            $display("FAIL pop_unexpected got %h exp none", data_out);
         end else begin
            e = expq.pop_front();
            if (data_out !== e)
               $display("FAIL pop_data got %h exp %h", data_out, e);
            else
               npass++;
         end
         mcount--;
      end
      if (acc) begin
         expq.push_back(d);
         mcount++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      w_en = 1'b0;
      r_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expq.delete();
      mcount = 0;
   endtask

   task automatic test_reset();
      do_reset();
      ntot++; if (count !== 5'd0) $display("FAIL rst_count got %0d exp 0", count); else npass++;
      ntot++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else npass++;
      ntot++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else npass++;
      ntot++; if (almost_empty !== 1'b1) $display("FAIL rst_aempty got %b exp 1", almost_empty); else npass++;
      ntot++; if (full !== 1'b0) $display("FAIL rst_full got %b exp 0", full); else npass++;
      ntot++; if (almost_full !== 1'b0) $display("FAIL rst_afull got %b exp 0", almost_full); else npass++;
      ntot++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else npass++;
      ntot++; if (underflow !== 1'b0) $display("FAIL rst_unf got %b exp 0", underflow); else npass++;
      ntot++; if (data_out !== 32'h0) $display("FAIL rst_dout got %h exp 0", data_out); else npass++;
   endtask

   task automatic test_latency();
      do_reset();
      cyc(1'b1, 32'hA5A5_0001, 1'b0);
      ntot++; if (count !== 5'd1) $display("FAIL lat_count got %0d exp 1", count); else npass++;
      ntot++; if (valid !== 1'b0) $display("FAIL lat_valid_n1 got %b exp 0", valid); else npass++;
      ntot++; if (empty !== 1'b1) $display("FAIL lat_empty_n1 got %b exp 1", empty); else npass++;
      cyc(1'b0, '0, 1'b0);
      ntot++; if (valid !== 1'b1) $display("FAIL lat_valid_n2 got %b exp 1", valid); else npass++;
      ntot++; if (data_out !== 32'hA5A5_0001) $display("FAIL lat_data got %h exp a5a50001", data_out); else npass++;
      cyc(1'b0, '0, 1'b1);
      ntot++; if (count !== 5'd0) $display("FAIL lat_count_pop got %0d exp 0", count); else npass++;
      ntot++; if (valid !== 1'b0) $display("FAIL lat_valid_pop got %b exp 0", valid); else npass++;
   endtask

   task automatic test_fill_overflow();
      int ec;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         cyc(1'b1, DW'(i), 1'b0);
         ec = (i + 1 > DEPTH) ? DEPTH : i + 1;
         ntot++; if (count !== ec[AL:0]) $display("FAIL fill_count i=%0d got %0d exp %0d", i, count, ec); else npass++;
         ntot++; if (almost_full !== (ec >= AF)) $display("FAIL fill_afull i=%0d got %b exp %b", i, almost_full, ec >= AF); else npass++;
         ntot++; if (full !== (ec == DEPTH)) $display("FAIL fill_full i=%0d got %b exp %b", i, full, ec == DEPTH); else npass++;
         ntot++; if (almost_empty !== (ec <= AE)) $display("FAIL fill_aempty i=%0d got %b exp %b", i, almost_empty, ec <= AE); else npass++;
         ntot++; if (overflow !== (i >= DEPTH)) $display("FAIL fill_ovf i=%0d got %b exp %b", i, overflow, i >= DEPTH); else npass++;
      end
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      ntot++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else npass++;
      ntot++; if (count !== 5'd16) $display("FAIL full_hold got %0d exp 16", count); else npass++;
      for (int k = 0; k < 40 && expq.size() > 0; k++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      ntot++; if (expq.size() != 0) $display("FAIL fill_drain left %0d exp 0", expq.size()); else npass++;
      ntot++; if (count !== 5'd0) $display("FAIL fill_drain_count got %0d exp 0", count); else npass++;
      ntot++; if (overflow !== 1'b1) $display("FAIL ovf_after_drain got %b exp 1", overflow); else npass++;
   endtask

   task automatic test_stream_wrap();
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, DW'(100 + i), 1'b0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      ntot++; if (count !== 5'd3) $display("FAIL stream_pre got %0d exp 3", count); else npass++;
      for (int i = 0; i < 40; i++) begin
         ntot++; if (valid !== 1'b1) $display("FAIL stream_gap i=%0d got %b exp 1", i, valid); else npass++;
         cyc(1'b1, DW'(200 + i), 1'b1);
         ntot++; if (count !== 5'd3) $display("FAIL stream_count i=%0d got %0d exp 3", i, count); else npass++;
      end
      for (int k = 0; k < 20 && expq.size() > 0; k++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      ntot++; if (expq.size() != 0) $display("FAIL stream_drain left %0d exp 0", expq.size()); else npass++;
   endtask

   task automatic test_underflow();
      do_reset();
      cyc(1'b1, 32'd11, 1'b0);
      cyc(1'b1, 32'd12, 1'b0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      for (int k = 0; k < 10 && valid === 1'b1; k++) cyc(1'b0, '0, 1'b1);
      r_en = 1'b0;
      ntot++; if (underflow !== 1'b0) $display("FAIL unf_early got %b exp 0", underflow); else npass++;
      ntot++; if (expq.size() != 0) $display("FAIL unf_drain left %0d exp 0", expq.size()); else npass++;
      repeat (3) cyc(1'b0, '0, 1'b1);
      ntot++; if (underflow !== 1'b1) $display("FAIL unf_set got %b exp 1", underflow); else npass++;
      ntot++; if (count !== 5'd0) $display("FAIL unf_count got %0d exp 0", count); else npass++;
      ntot++; if (almost_empty !== 1'b1) $display("FAIL unf_aempty got %b exp 1", almost_empty); else npass++;
      cyc(1'b0, '0, 1'b0);
      ntot++; if (underflow !== 1'b1) $display("FAIL unf_sticky got %b exp 1", underflow); else npass++;
      cyc(1'b1, 32'h55, 1'b0);
      ntot++; if (valid !== 1'b0) $display("FAIL unf_wr_n1 got %b exp 0", valid); else npass++;
      cyc(1'b0, '0, 1'b0);
      ntot++; if (valid !== 1'b1) $display("FAIL unf_wr_n2 got %b exp 1", valid); else npass++;
      ntot++; if (data_out !== 32'h55) $display("FAIL unf_wr_data got %h exp 55", data_out); else npass++;
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 9; i++) cyc(1'b1, DW'(300 + i), 1'b0);
      ntot++; if (count !== 5'd9) $display("FAIL mid_pre got %0d exp 9", count); else npass++;
      w_en    = 1'b1;
      r_en    = 1'b1;
      data_in = 32'd999;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      w_en = 1'b0;
      r_en = 1'b0;
      expq.delete();
      mcount = 0;
      ntot++; if (count !== 5'd0) $display("FAIL mid_count got %0d exp 0", count); else npass++;
      ntot++; if (valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", valid); else npass++;
      ntot++; if (empty !== 1'b1) $display("FAIL mid_empty got %b exp 1", empty); else npass++;
      ntot++; if (almost_empty !== 1'b1) $display("FAIL mid_aempty got %b exp 1", almost_empty); else npass++;
      ntot++; if (data_out !== 32'h0) $display("FAIL mid_dout got %h exp 0", data_out); else npass++;
      cyc(1'b1, 32'h1234, 1'b0);
      cyc(1'b0, '0, 1'b0);
      ntot++; if (valid !== 1'b1) $display("FAIL mid_new_valid got %b exp 1", valid); else npass++;
      ntot++; if (data_out !== 32'h1234) $display("FAIL mid_new_data got %h exp 1234", data_out); else npass++;
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      ntot++; if (valid !== 1'b0) $display("FAIL mid_stale got %b exp 0", valid); else npass++;
      ntot++; if (count !== 5'd0) $display("FAIL mid_end_count got %0d exp 0", count); else npass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_latency();
      test_fill_overflow();
      test_stream_wrap();
      test_underflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
